// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
//
// Purpose:
//   Shared definitions for the binarised dense-layer pipeline. The serializer
//   and the weight-ROM generator both use the chunk-order constant, so the
//   chunk order is fixed here and nowhere else.
//
// Contents:
//   LSB_FIRST    - chunk-order convention. 1 means chunk 0 is the least
//                  significant OUT_W bits of a vector.
//   StreamState  - serializer FSM state type (IDLE, STREAM).
//   ctrWidth()   - counter width helper built on $clog2. It never returns
//                  less than one bit.
// ---------------------------------------------------------------------------
package bnn_pkg;

   // Chunk ordering shared with the weight-ROM generator. A value of 1 means
   // the lowest-order slice of the activation vector goes out first.
   localparam int LSB_FIRST = 1;

   // Serializer FSM states. IDLE means no frame is on the output. STREAM
   // means a frame is being replayed chunk by chunk.
   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } StreamState;

   // Width of a counter that has to index n positions. The result is clamped
   // to one bit so that a degenerate n cannot produce a zero-width vector.
   function automatic int ctrWidth(input int n);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/dense_serializer.sv
// ---------------------------------------------------------------------------
// dense_serializer
//
// Purpose:
//   Takes one IN_SIZE-bit binary activation vector through a valid/ready
//   handshake. It replays that vector as a gap-free stream of OUT_W-bit
//   chunks, one chunk per clock, lowest chunk first. A single-cycle vld_out
//   pulse marks chunk 0 of every frame. This is the vld_in/data_in sequence
//   the next dense layer's accumulate counter consumes.
//
//   Storage has two entries: the active shift register and a hold register.
//   A new vector can therefore be accepted while the current one is still
//   streaming, and back-to-back frames leave with no idle cycle between them.
//
// Parameters:
//   IN_SIZE  - width of the parallel input vector.
//   OUT_W    - chunk width per cycle. Must equal the downstream INPUT_SIZE.
//   NUM_CYC  - derived: cycles per frame. Must be a power of two.
//   BW       - derived: width of the chunk index.
//
// Ports:
//   clk       in   1        clock
//   rst       in   1        synchronous active-high reset
//   in_vld    in   1        input vector valid
//   in_rdy    out  1        a vector can be accepted this cycle
//   in_data   in   IN_SIZE  binary activation vector
//   vld_out   out  1        pulse on chunk 0 of each frame
//   data_out  out  OUT_W    current chunk
//   cyc_idx   out  BW       index of the chunk on data_out
//   busy      out  1        a frame is streaming this cycle
// ---------------------------------------------------------------------------
module dense_serializer
   import bnn_pkg::*;
#(
   parameter  int IN_SIZE = 128,
   parameter  int OUT_W   = 4,
   localparam int NUM_CYC = IN_SIZE / OUT_W,
   localparam int BW      = ctrWidth(NUM_CYC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [IN_SIZE-1:0] in_data,
   output logic               vld_out,
   output logic [OUT_W-1:0]   data_out,
   output logic [BW-1:0]      cyc_idx,
   output logic               busy
);

   localparam logic [BW-1:0] LAST_CNT = BW'(NUM_CYC - 1);

   // The frame geometry has to split evenly into chunks. The chunk count has
   // to be a power of two of at least 2, so that the counter wraps to 0 on its
   // own exactly when the downstream power-of-two counter does. The shift
   // direction below assumes the lowest chunk goes out first.
   if ((IN_SIZE % OUT_W) != 0 || NUM_CYC < 2 ||
       (NUM_CYC & (NUM_CYC - 1)) != 0) begin : gBadGeometry
      $error("dense_serializer: IN_SIZE/OUT_W must be an integer power of two >= 2");
   end

   if (LSB_FIRST != 1) begin : gBadOrder
      $error("dense_serializer: only LSB-first chunk order is implemented");
   end

   StreamState         state_q, state_d;
   logic [IN_SIZE-1:0] act_q, act_d;
   logic [IN_SIZE-1:0] hold_q, hold_d;
   logic               holdFull_q, holdFull_d;
   logic [BW-1:0]      cnt_q, cnt_d;
   logic               vld_q, vld_d;

   logic               transfer;
   logic               lastChunk;

   // Only the hold register can refuse a vector. When the hold register is
   // empty there is always somewhere to put an incoming vector: straight into
   // the shift register when idle or on the last chunk, and into the hold
   // register otherwise. Reset also blocks acceptance, so a vector offered
   // while rst is high is never half-taken.
   assign in_rdy    = !holdFull_q && !rst;
   assign transfer  = in_vld && in_rdy;
   assign lastChunk = (state_q == STREAM) && (cnt_q == LAST_CNT);

   // Next-state logic.
   //
   // While streaming, the shift register moves right by one chunk every
   // cycle. The bits shifted in are zero, so after the final chunk the
   // register is already clear. The chunk counter runs over exactly NUM_CYC
   // values, so it wraps back to 0 on the last chunk without an explicit
   // clear. Together these make data_out and cyc_idx read 0 in IDLE with no
   // output muxing.
   //
   // On the last chunk the next frame comes from one of two places. A vector
   // waiting in the hold register has priority. Otherwise a vector arriving
   // in that same cycle loads straight into the shift register. Either way
   // the stream continues with no gap. A transfer on any other streaming
   // cycle parks the vector in the hold register.
   //
   // vld_q is computed from the next state, which makes the chunk-0 pulse a
   // plain registered output.
   always_comb begin
      state_d    = state_q;
      act_d      = act_q;
      hold_d     = hold_q;
      holdFull_d = holdFull_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (transfer) begin
               act_d   = in_data;
               cnt_d   = '0;
               state_d = STREAM;
            end
         end

         STREAM: begin
            act_d = act_q >> OUT_W;
            cnt_d = cnt_q + BW'(1);
            if (lastChunk) begin
               if (holdFull_q) begin
                  act_d      = hold_q;
                  holdFull_d = 1'b0;
               end else if (transfer) begin
                  act_d = in_data;
               end else begin
                  state_d = IDLE;
               end
            end else if (transfer) begin
               hold_d     = in_data;
               holdFull_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      vld_d = (state_d == STREAM) && (cnt_d == '0);
   end

   // State register. Reset drops any frame in flight and any held vector.
   // The shift register and counter are cleared so that every output reads 0
   // from the first cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         act_q      <= '0;
         hold_q     <= '0;
         holdFull_q <= 1'b0;
         cnt_q      <= '0;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         hold_q     <= hold_d;
         holdFull_q <= holdFull_d;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
      end
   end

   // Every output except in_rdy comes straight from a register.
   assign vld_out  = vld_q;
   assign data_out = act_q[OUT_W-1:0];
   assign cyc_idx  = cnt_q;
   assign busy     = (state_q == STREAM);

endmodule

// File: tb/tb_dense_serializer.sv
// ---------------------------------------------------------------------------
// tb_dense_serializer
//
// Directed bench for dense_serializer with IN_SIZE=16, OUT_W=4 (four chunks
// per frame). Inputs change one time unit after each rising edge. Outputs
// are sampled on the falling edge of the same cycle, so each row of the
// vector table describes one clock cycle: what is driven during that cycle,
// and what the outputs show during it.
// ---------------------------------------------------------------------------
module tb_dense_serializer;

   localparam int IN_SIZE = 16;
   localparam int OUT_W   = 4;
   localparam int BW      = 2;

   logic               clk;
   logic               rst;
   logic               in_vld;
   logic               in_rdy;
   logic [IN_SIZE-1:0] in_data;
   logic               vld_out;
   logic [OUT_W-1:0]   data_out;
   logic [BW-1:0]      cyc_idx;
   logic               busy;

   int assertCount = 0;
   int failCount   = 0;

   dense_serializer #(
      .IN_SIZE (IN_SIZE),
      .OUT_W   (OUT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .vld_out  (vld_out),
      .data_out (data_out),
      .cyc_idx  (cyc_idx),
      .busy     (busy)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One clock cycle of stimulus plus the outputs expected during that cycle.
   typedef struct {
      logic        rst;
      logic        vld;
      logic [15:0] data;
      logic        expVld;
      logic [3:0]  expData;
      logic [1:0]  expIdx;
      logic        expBusy;
      logic        expRdy;
   } VecRow;

   VecRow rows[$];

   // Appends one row to the vector table.
   task automatic addRow(input logic r, input logic v, input logic [15:0] d,
                         input logic eV, input logic [3:0] eD, input logic [1:0] eI,
                         input logic eB, input logic eR);
      VecRow row;
      row.rst = r;  row.vld = v;  row.data = d;
      row.expVld = eV;  row.expData = eD;  row.expIdx = eI;
      row.expBusy = eB; row.expRdy = eR;
      rows.push_back(row);
   endtask

   // Drives the DUT inputs for the current cycle.
   task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d);
      rst     = r;
      in_vld  = v;
      in_data = d;
   endtask

   // Compares one observed value against its expected value and counts it.
   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Moves to the next cycle: inputs may change one unit after the edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Returns chunk k of a 16-bit vector, lowest chunk first.
   function automatic logic [3:0] nib(input logic [15:0] v, input int k);
      return v[k*4 +: 4];
   endfunction

   // Hold-full scenario state.
   logic [15:0] vecA, vecB, vecC;
   logic        obsVld [1:13];
   logic [3:0]  obsData[1:13];
   logic        cTaken;
   int          cTakeCyc;

   initial begin
      // Reset, then a single frame.
      addRow(1, 0, 16'h0000, 0, 4'h0, 2'd0, 0, 0);
      addRow(1, 0, 16'h0000, 0, 4'h0, 2'd0, 0, 0);
      addRow(0, 1, 16'hA5C3, 0, 4'h0, 2'd0, 0, 1);
      addRow(0, 0, 16'h0000, 1, 4'h3, 2'd0, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'hC, 2'd1, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h5, 2'd2, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'hA, 2'd3, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h0, 2'd0, 0, 1);
      // Back-to-back: the second vector goes through the hold register.
      addRow(0, 1, 16'h1234, 0, 4'h0, 2'd0, 0, 1);
      addRow(0, 1, 16'h5678, 1, 4'h4, 2'd0, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h3, 2'd1, 1, 0);
      addRow(0, 0, 16'h0000, 0, 4'h2, 2'd2, 1, 0);
      addRow(0, 0, 16'h0000, 0, 4'h1, 2'd3, 1, 0);
      addRow(0, 0, 16'h0000, 1, 4'h8, 2'd0, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h7, 2'd1, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h6, 2'd2, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h5, 2'd3, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h0, 2'd0, 0, 1);
      // Direct load on the last chunk while the hold register is empty.
      addRow(0, 1, 16'h0000, 0, 4'h0, 2'd0, 0, 1);
      addRow(0, 0, 16'h0000, 1, 4'h0, 2'd0, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h0, 2'd1, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h0, 2'd2, 1, 1);
      addRow(0, 1, 16'hFFFF, 0, 4'h0, 2'd3, 1, 1);
      addRow(0, 0, 16'h0000, 1, 4'hF, 2'd0, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'hF, 2'd1, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'hF, 2'd2, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'hF, 2'd3, 1, 1);
      addRow(0, 0, 16'h0000, 0, 4'h0, 2'd0, 0, 1);

      // Run one reset cycle first so that the registers are defined when the
      // table starts.
      applyStimulus(1, 0, 16'h0000);
      nextCycle();

      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i].rst, rows[i].vld, rows[i].data);
         @(negedge clk);
         checkOutput($sformatf("row%0d vld_out", i),  16'(vld_out),  16'(rows[i].expVld));
         checkOutput($sformatf("row%0d data_out", i), 16'(data_out), 16'(rows[i].expData));
         checkOutput($sformatf("row%0d cyc_idx", i),  16'(cyc_idx),  16'(rows[i].expIdx));
         checkOutput($sformatf("row%0d busy", i),     16'(busy),     16'(rows[i].expBusy));
         checkOutput($sformatf("row%0d in_rdy", i),   16'(in_rdy),   16'(rows[i].expRdy));
         nextCycle();
      end

      // Hold full. A goes straight into the shift register and B into hold.
      // C is offered continuously and must wait for in_rdy. C is accepted when
      // B moves out of hold, on the cycle B's frame starts (cycle 5), and it
      // streams from cycle 9: exactly one frame after B.
      vecA = 16'h1357;
      vecB = 16'h2468;
      vecC = 16'h9ABC;
      cTaken   = 1'b0;
      cTakeCyc = -1;
      applyStimulus(0, 1, vecA);
      @(negedge clk);
      checkOutput("hold a_rdy", 16'(in_rdy), 16'd1);
      nextCycle();
      for (int cyc = 1; cyc <= 13; cyc++) begin
         if (cyc == 1) begin
            applyStimulus(0, 1, vecB);
         end else if (!cTaken) begin
            applyStimulus(0, 1, vecC);
         end else begin
            applyStimulus(0, 0, 16'h0000);
         end
         @(negedge clk);
         obsVld[cyc]  = vld_out;
         obsData[cyc] = data_out;
         if (cyc == 1) begin
            checkOutput("hold b_rdy", 16'(in_rdy), 16'd1);
         end else if (!cTaken && in_rdy) begin
            cTaken   = 1'b1;
            cTakeCyc = cyc;
         end
         nextCycle();
      end
      applyStimulus(0, 0, 16'h0000);
      if (!cTaken) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL hold c_accept: in_rdy never returned within 13 cycles, expected accept at cycle 5");
      end else begin
         checkOutput("hold c_take_cycle", 16'(cTakeCyc), 16'd5);
      end
      for (int cyc = 1; cyc <= 12; cyc++) begin
         logic [15:0] v;
         v = (cyc <= 4) ? vecA : (cyc <= 8) ? vecB : vecC;
         checkOutput($sformatf("hold vld c%0d", cyc), 16'(obsVld[cyc]),
                     16'(((cyc - 1) % 4) == 0));
         checkOutput($sformatf("hold data c%0d", cyc), 16'(obsData[cyc]),
                     16'(nib(v, (cyc - 1) % 4)));
      end
      checkOutput("hold vld c13", 16'(obsVld[13]), 16'd0);
      checkOutput("hold data c13", 16'(obsData[13]), 16'd0);

      // Reset mid-frame. Start frame BEEF, assert rst on chunk 2, hold it for
      // two cycles, then stream a fresh frame from chunk 0.
      applyStimulus(0, 1, 16'hBEEF);
      nextCycle();
      applyStimulus(0, 0, 16'h0000);
      @(negedge clk);
      checkOutput("rst chunk0", 16'(data_out), 16'hF);
      nextCycle();
      @(negedge clk);
      checkOutput("rst chunk1", 16'(data_out), 16'hE);
      nextCycle();
      applyStimulus(1, 0, 16'h0000);
      @(negedge clk);
      checkOutput("rst rdy_in_rst", 16'(in_rdy), 16'd0);
      checkOutput("rst chunk2_busy", 16'(busy), 16'd1);
      checkOutput("rst chunk2_idx", 16'(cyc_idx), 16'd2);
      nextCycle();
      @(negedge clk);
      checkOutput("rst vld_out", 16'(vld_out), 16'd0);
      checkOutput("rst data_out", 16'(data_out), 16'd0);
      checkOutput("rst busy", 16'(busy), 16'd0);
      checkOutput("rst in_rdy", 16'(in_rdy), 16'd0);
      checkOutput("rst cyc_idx", 16'(cyc_idx), 16'd0);
      nextCycle();
      applyStimulus(0, 1, 16'h0F1E);
      @(negedge clk);
      checkOutput("post_rst in_rdy", 16'(in_rdy), 16'd1);
      checkOutput("post_rst busy", 16'(busy), 16'd0);
      checkOutput("post_rst data_out", 16'(data_out), 16'd0);
      nextCycle();
      applyStimulus(0, 0, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("post_rst vld k%0d", k), 16'(vld_out), 16'(k == 0));
         checkOutput($sformatf("post_rst data k%0d", k), 16'(data_out), 16'(nib(16'h0F1E, k)));
         checkOutput($sformatf("post_rst idx k%0d", k), 16'(cyc_idx), 16'(k));
         nextCycle();
      end
      @(negedge clk);
      checkOutput("post_rst idle busy", 16'(busy), 16'd0);
      checkOutput("post_rst idle vld", 16'(vld_out), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
